// File: rtl/instr_mem_dumper.sv
// Streams the instruction memory out over a byte-wide transmit handshake:
// one count byte, then each word MSB first, reading words one at a time.
module instr_mem_dumper #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INPUT_BYTE     = 8,
  parameter int unsigned N_INSTRUCTIONS = 8,
  parameter int unsigned ADDR_WIDTH     = $clog2(N_INSTRUCTIONS)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [7:0]            n_words,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [INPUT_BYTE-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BytesPerWord = DATA_WIDTH / INPUT_BYTE;
  localparam logic [7:0]  LastByte     = 8'(BytesPerWord - 1);
  localparam logic [7:0]  MaxCnt       = 8'(N_INSTRUCTIONS);

  typedef enum logic [2:0] {
    StIdle,
    StSendCnt,
    StRdReq,
    StRdWait,
    StSendByte,
    StFinish
  } state_e;

  state_e                state_q;
  logic [7:0]            count_q;
  logic [7:0]            idx_q;
  logic [7:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [7:0]            eff_cnt;
  logic [7:0]            idx_next;

  assign eff_cnt  = (n_words > MaxCnt) ? MaxCnt : n_words;
  assign idx_next = idx_q + 8'd1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q    <= eff_cnt;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            tx_data    <= INPUT_BYTE'(eff_cnt);
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
            state_q    <= StSendCnt;
          end
        end
        StSendCnt: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (count_q != 8'd0) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
              state_q   <= StRdReq;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StFinish;
            end
          end
        end
        StRdReq: begin
          mem_rd_en <= 1'b0;
          state_q   <= StRdWait;
        end
        StRdWait: begin
          word_q     <= mem_rdata;
          tx_data    <= mem_rdata[DATA_WIDTH-1 -: INPUT_BYTE];
          tx_valid   <= 1'b1;
          byte_cnt_q <= '0;
          state_q    <= StSendByte;
        end
        StSendByte: begin
          if (tx_ready) begin
            if (byte_cnt_q == LastByte) begin
              tx_valid <= 1'b0;
              if (idx_next < count_q) begin
                idx_q     <= idx_next;
                mem_addr  <= ADDR_WIDTH'(idx_next);
                mem_rd_en <= 1'b1;
                state_q   <= StRdReq;
              end else begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StFinish;
              end
            end else begin
              // Next byte comes from the bits just below the one being sent.
              byte_cnt_q <= byte_cnt_q + 8'd1;
              word_q     <= word_q << INPUT_BYTE;
              tx_data    <= word_q[DATA_WIDTH-INPUT_BYTE-1 -: INPUT_BYTE];
            end
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_dumper.sv
// Directed bench for instr_mem_dumper: a synchronous memory model, a byte
// monitor on the transmit handshake, and hand-computed expected streams.
module tb_instr_mem_dumper;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n_words = 8'd0;
  logic        mem_rd_en;
  logic [2:0]  mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  instr_mem_dumper #(
    .DATA_WIDTH    (32),
    .INPUT_BYTE    (8),
    .N_INSTRUCTIONS(8)
  ) u_dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .n_words  (n_words),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8];
  initial begin
    mem[0] = 32'h0000_0513;
    mem[1] = 32'h0010_0593;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'h1234_5678;
    mem[4] = 32'hA5A5_5A5A;
    mem[5] = 32'h0BAD_F00D;
    mem[6] = 32'hCAFE_0001;
    mem[7] = 32'h8000_00FF;
  end

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Monitor: captures transfers, read strobes and done pulses at the edge.
  byte unsigned bytes_q[$];
  int          stamps_q[$];
  int          addrs_q[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) begin
      bytes_q.push_back(tx_data);
      stamps_q.push_back(cyc);
    end
    if (mem_rd_en) begin
      rd_cnt++;
      addrs_q.push_back(int'(mem_addr));
    end
    if (done) done_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;
  int b0, a0, r0, d0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b0 = bytes_q.size();
    a0 = addrs_q.size();
    r0 = rd_cnt;
    d0 = done_cnt;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    start   = 1'b1;
    n_words = n;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_stream(input string tag, input byte unsigned exp[$]);
    check_eq({tag, "_len"}, 32'(bytes_q.size() - b0), 32'(exp.size()));
    for (int i = 0; i < exp.size() && b0 + i < bytes_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[b0+i]), 32'(exp[i]));
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq(tag, {17'd0, tx_valid, tx_data, mem_rd_en, mem_addr, busy, done}, 32'd0);
  endtask

  byte unsigned exp_basic[$] = '{8'h02, 8'h00, 8'h00, 8'h05, 8'h13, 8'h00, 8'h10, 8'h05, 8'h93};
  byte unsigned exp_q[$];
  logic         found;

  initial begin
    // Reset held low for 30 ns; outputs quiet during and after.
    #15;
    check_outs_zero("rst_during");
    #15 arst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outs_zero("rst_after");

    // Basic two-word dump with tx_ready high.
    snap();
    pulse_start(8'd2);
    check_eq("basic_first_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("basic_first_data", 32'(tx_data), 32'h02);
    check_eq("basic_busy", {31'd0, busy}, 32'd1);
    wait_done("basic");
    check_stream("basic", exp_basic);
    check_eq("basic_rd_pulses", 32'(rd_cnt - r0), 32'd2);
    if (addrs_q.size() >= a0 + 2) begin
      check_eq("basic_addr0", 32'(addrs_q[a0]), 32'd0);
      check_eq("basic_addr1", 32'(addrs_q[a0+1]), 32'd1);
    end
    if (stamps_q.size() >= b0 + 6) begin
      check_eq("basic_gap_cnt_to_data", 32'(stamps_q[b0+1] - stamps_q[b0]), 32'd3);
      check_eq("basic_gap_in_word", 32'(stamps_q[b0+2] - stamps_q[b0+1]), 32'd1);
      check_eq("basic_gap_between_words", 32'(stamps_q[b0+5] - stamps_q[b0+4]), 32'd3);
    end

    // Backpressure while 0x05 is offered.
    snap();
    pulse_start(8'd2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tx_valid && tx_data == 8'h05) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("bp_found", {31'd0, found}, 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_hold_valid%0d", i), {31'd0, tx_valid}, 32'd1);
      check_eq($sformatf("bp_hold_data%0d", i), 32'(tx_data), 32'h05);
    end
    check_eq("bp_no_transfer", 32'(bytes_q.size() - b0), 32'd3);
    tx_ready = 1'b1;
    wait_done("bp");
    check_stream("bp", exp_basic);

    // Zero words: just the count byte.
    snap();
    pulse_start(8'd0);
    wait_done("zero");
    exp_q = '{8'h00};
    check_stream("zero", exp_q);
    check_eq("zero_rd_pulses", 32'(rd_cnt - r0), 32'd0);

    // Request beyond depth clamps to 8 words.
    snap();
    pulse_start(8'd20);
    wait_done("clamp");
    exp_q = '{8'h08};
    for (int w = 0; w < 8; w++)
      for (int k = 3; k >= 0; k--) exp_q.push_back(mem[w][8*k +: 8]);
    check_stream("clamp", exp_q);
    check_eq("clamp_rd_pulses", 32'(rd_cnt - r0), 32'd8);
    for (int w = 0; w < 8 && a0 + w < addrs_q.size(); w++)
      check_eq($sformatf("clamp_addr%0d", w), 32'(addrs_q[a0+w]), 32'(w));

    // A second start during a dump has no effect.
    snap();
    pulse_start(8'd2);
    repeat (4) @(negedge clk);
    pulse_start(8'd1);
    wait_done("busy_start");
    check_stream("busy_start", exp_basic);

    // Reset after the third byte aborts the dump.
    snap();
    pulse_start(8'd2);
    for (int i = 0; i < 100 && bytes_q.size() < b0 + 3; i++) @(negedge clk);
    arst_n = 1'b0;
    #1;
    check_outs_zero("midrst_outputs");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("midrst_bytes", 32'(bytes_q.size() - b0), 32'd3);
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    snap();
    pulse_start(8'd2);
    wait_done("after_rst");
    check_stream("after_rst", exp_basic);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_dumper.md
INSTR_MEM_DUMPER -- requirements
Module: instr_mem_dumper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, instruction word width in bits.
REQ-002 SHALL have parameter INPUT_BYTE, 8, serial byte width in bits.
REQ-003 SHALL have parameter N_INSTRUCTIONS, 8, memory depth in words and maximum words dumped.
REQ-004 SHALL have parameter ADDR_WIDTH, $clog2(N_INSTRUCTIONS), memory address width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a dump; ignored while busy.
REQ-008 SHALL have port n_words  input  8  requested word count, sampled only on the accepted start cycle.
REQ-009 SHALL have port mem_rd_en  output  1  synchronous read strobe to instruction memory.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  word address of the current read.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
REQ-012 SHALL have port tx_data  output  INPUT_BYTE  byte offered to the UART transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-014 SHALL have port tx_ready  input  1  transmitter accepts the byte.
REQ-015 SHALL have port busy  output  1  dump in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-017 SHALL emit the stream format the loader consumes: one count byte, then 4 bytes per word, MSB first ([31:24], [23:16], [15:8], [7:0]).
REQ-018 SHALL use effective count = min(n_words, N_INSTRUCTIONS); the count byte carries the effective count, not the raw n_words.
REQ-019 SHALL read words from addresses 0 to effective count - 1 in ascending order.
REQ-020 SHALL implement FSM states IDLE, SEND_CNT, RD_REQ, RD_WAIT, SEND_BYTE, FINISH.
REQ-021 SHALL transition IDLE->SEND_CNT on start; tx_valid rises with the count byte the cycle after start.
REQ-022 SHALL transition SEND_CNT->RD_REQ on count-byte acceptance if count>0, else SEND_CNT->FINISH.
REQ-023 SHALL assert mem_rd_en for exactly one cycle in RD_REQ with mem_addr = word index, then enter RD_WAIT.
REQ-024 SHALL capture mem_rdata into a word shift register in RD_WAIT, then enter SEND_BYTE with tx_valid asserted the next cycle.
REQ-025 SHALL count a byte transfer only on a rising edge with tx_valid=1 and tx_ready=1.
REQ-026 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0; tx_valid never drops without a transfer.
REQ-027 SHALL shift left by INPUT_BYTE on each accepted data byte; after the 4th, go to RD_REQ (index+1) if words remain, else FINISH.
REQ-028 SHALL pulse done for exactly one cycle in FINISH, deassert busy in that same cycle, and return to IDLE.
REQ-029 SHALL assert busy in every state except IDLE and FINISH.
REQ-030 SHALL keep tx_valid=0 in RD_REQ, RD_WAIT, FINISH, IDLE; mem_rd_en=0 outside RD_REQ.
REQ-031 SHALL with tx_ready held high produce one byte per cycle within a word and 2 idle cycles between words.

Reset
REQ-032 SHALL on arst_n=0 immediately force IDLE and tx_valid=0, tx_data=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, internal counters and word register 0.
REQ-033 SHALL abort any dump on reset mid-operation with no further bytes; a start after release begins a fresh dump from the count byte.

Verification
REQ-034 SHALL cover reset: arst_n low 30 ns -> all outputs 0 during and after reset until start.
REQ-035 SHALL cover basic dump: mem[0]=0x00000513, mem[1]=0x00100593, n_words=2, tx_ready=1 -> bytes 02,00,00,05,13,00,10,05,93 then one done pulse.
REQ-036 SHALL cover backpressure: tx_ready low 3 cycles while byte 0x05 offered -> tx_data=0x05 and tx_valid=1 held, no byte lost or duplicated.
REQ-037 SHALL cover zero/clamp: n_words=0 -> single byte 00 then done; n_words=20 with N_INSTRUCTIONS=8 -> count byte 08 then 32 data bytes from addresses 0..7.
REQ-038 SHALL cover start while busy -> ignored, stream unchanged, exactly one done pulse.
REQ-039 SHALL cover reset asserted after the 3rd byte -> tx_valid=0 immediately; next start gives full stream from count byte.
